// File: rtl/morse_tx_scheduler.sv
// Message-level scheduler sharing one Morse engine and translator between two requesters.
// Build option: define MORSE_SCHED_PRIORITY_EN to give requester 1 fixed priority on ties.
module morse_tx_scheduler #(
  parameter int unsigned UNIT_CYCLES      = 32'd6250000,
  parameter int unsigned LETTER_GAP_UNITS = 32'd2,
  parameter int unsigned WORD_GAP_UNITS   = 32'd7
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Req0_Valid,
  input  logic [7:0] i_Req0_Char,
  input  logic       i_Req0_Last,
  output logic       o_Req0_Ready,
  input  logic       i_Req1_Valid,
  input  logic [7:0] i_Req1_Char,
  input  logic       i_Req1_Last,
  output logic       o_Req1_Ready,
  output logic [7:0] o_Char,
  input  logic       i_Char_Known,
  output logic       o_Morse_Start,
  input  logic       i_Morse_Done,
  output logic [1:0] o_Grant,
  output logic       o_Busy
);

  localparam logic [31:0] LETTER_TGT  = 32'(LETTER_GAP_UNITS * UNIT_CYCLES);
  localparam logic [31:0] WORD_TGT    = 32'(WORD_GAP_UNITS * UNIT_CYCLES);
  localparam logic [7:0]  ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  ready_q, ready_d;
  logic        rr_q, rr_d;
  logic        last_q, last_d;
  logic [7:0]  char_q, char_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] tgt_q, tgt_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;

  logic [1:0]  pick_s;
  logic        xfer_s;
  logic [7:0]  sel_char_s;
  logic        sel_last_s;
  logic        gap_end_s;

  assign xfer_s     = (ready_q[0] & i_Req0_Valid) | (ready_q[1] & i_Req1_Valid);
  assign sel_char_s = grant_q[1] ? i_Req1_Char : i_Req0_Char;
  assign sel_last_s = grant_q[1] ? i_Req1_Last : i_Req0_Last;
  // A zero target still spends one cycle in GAP.
  assign gap_end_s  = (tgt_q == 32'd0) || (cnt_q == (tgt_q - 32'd1));

  // Message-boundary arbitration between the two requesters.
  always_comb begin
    pick_s = 2'b00;
    if (i_Req0_Valid && i_Req1_Valid) begin
`ifdef MORSE_SCHED_PRIORITY_EN
      pick_s = 2'b10;
`else
      pick_s = rr_q ? 2'b01 : 2'b10;
`endif
    end else if (i_Req0_Valid) begin
      pick_s = 2'b01;
    end else if (i_Req1_Valid) begin
      pick_s = 2'b10;
    end else begin
      pick_s = 2'b00;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    last_d  = last_q;
    char_d  = char_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_s != 2'b00) begin
          grant_d = pick_s;
          state_d = S_FETCH;
        end else begin
          grant_d = 2'b00;
        end
      end
      S_FETCH: begin
        if (xfer_s) begin
          char_d = sel_char_s;
          last_d = sel_last_s;
          if (sel_char_s == ASCII_SPACE) begin
            tgt_d   = WORD_TGT;
            cnt_d   = 32'd0;
            state_d = S_GAP;
          end else begin
            state_d = S_START;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_START: begin
        if (i_Char_Known) begin
          start_d = 1'b1;
          state_d = S_WAIT;
        end else if (last_q) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          rr_d    = grant_q[1];
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (i_Morse_Done) begin
          tgt_d   = LETTER_TGT;
          cnt_d   = 32'd0;
          state_d = S_GAP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_end_s) begin
          if (last_q) begin
            state_d = S_IDLE;
            grant_d = 2'b00;
            rr_d    = grant_q[1];
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
    ready_d = (state_d == S_FETCH) ? grant_d : 2'b00;
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any message in flight.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      ready_q <= 2'b00;
      rr_q    <= 1'b1;
      last_q  <= 1'b0;
      char_q  <= 8'h00;
      cnt_q   <= 32'd0;
      tgt_q   <= 32'd0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ready_q <= ready_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      char_q  <= char_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign o_Req0_Ready  = ready_q[0];
  assign o_Req1_Ready  = ready_q[1];
  assign o_Char        = char_q;
  assign o_Morse_Start = start_q;
  assign o_Grant       = grant_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Self-checking bench for morse_tx_scheduler: directed table, corner sequences, random messages.
module tb_morse_tx_scheduler;

  localparam int UNIT       = 4;
  localparam int LGAP       = 2;
  localparam int WGAP       = 7;
  localparam int LETTER_CYC = LGAP * UNIT;
  localparam int WORD_CYC   = WGAP * UNIT;
  localparam int TMO        = 2000;
  localparam int NM         = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       req_valid [2];
  logic [7:0] req_char  [2];
  logic       req_last  [2];
  logic       rdy0, rdy1, known, done, start, busy;
  logic [7:0] o_char;
  logic [1:0] grant;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int eng_delay = 10;
  bit eng_rand = 1'b0;
  bit eng_en = 1'b1;

  typedef struct { logic [1:0] gnt; logic [7:0] ch; logic last; int cyc; } ev_t;
  typedef struct { int req; string msg; int starts; int dur; } vec_t;

  ev_t        xq[$];
  ev_t        sq[$];
  logic [1:0] gq[$];
  int         iq[$];
  int         dq[$];

  morse_tx_scheduler #(
    .UNIT_CYCLES(UNIT), .LETTER_GAP_UNITS(LGAP), .WORD_GAP_UNITS(WGAP)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n),
    .i_Req0_Valid(req_valid[0]), .i_Req0_Char(req_char[0]), .i_Req0_Last(req_last[0]),
    .o_Req0_Ready(rdy0),
    .i_Req1_Valid(req_valid[1]), .i_Req1_Char(req_char[1]), .i_Req1_Last(req_last[1]),
    .o_Req1_Ready(rdy1),
    .o_Char(o_char), .i_Char_Known(known), .o_Morse_Start(start), .i_Morse_Done(done),
    .o_Grant(grant), .o_Busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic is_known(input logic [7:0] c);
    return (c >= 8'h41 && c <= 8'h5A) || (c >= 8'h30 && c <= 8'h39);
  endfunction

  // Cycles from one transfer to the next transfer (or release) for a given character.
  function automatic int char_span(input logic [7:0] c, input int d);
    if (is_known(c)) return 2 + d + LETTER_CYC + 1;
    else if (c == 8'h20) return WORD_CYC + 1;
    else return 2;
  endfunction

  // Combinational translator model.
  always_comb known = is_known(o_char);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Morse engine model: Done pulses a fixed or random number of cycles after Start.
  initial begin
    int d;
    done = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_en && rst_n && start) begin
        d = eng_rand ? int'($urandom_range(5, 1)) : eng_delay;
        repeat (d) @(posedge clk);
        #1;
        if (eng_en) done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
      end
    end
  end

  // Event monitor sampling on the falling edge.
  initial begin
    logic [1:0] pg;
    logic       pb;
    pg = 2'b00;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pg = 2'b00;
        pb = 1'b0;
      end else begin
        check("ready_owner", 64'({rdy1, rdy0} & ~grant), 64'd0);
        if (rdy0 && req_valid[0]) xq.push_back('{2'b01, req_char[0], req_last[0], cyc});
        if (rdy1 && req_valid[1]) xq.push_back('{2'b10, req_char[1], req_last[1], cyc});
        if (start) sq.push_back('{grant, o_char, 1'b0, cyc});
        if (done) dq.push_back(cyc);
        if (grant != 2'b00 && pg == 2'b00) gq.push_back(grant);
        if (!busy && pb) iq.push_back(cyc);
        pg = grant;
        pb = busy;
      end
    end
  end

  task automatic clear_logs();
    xq.delete(); sq.delete(); gq.delete(); iq.delete(); dq.delete();
  endtask

  task automatic send_msg(input int r, input string m, input int gmin, input int gmax,
                          output int v_cyc);
    int  t;
    int  g;
    bit  got;
    v_cyc = cyc;
    for (int i = 0; i < m.len(); i++) begin
      g = (i > 0) ? int'($urandom_range(gmax, gmin)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      req_valid[r] = 1'b1;
      req_char[r]  = m[i];
      req_last[r]  = (i == m.len() - 1);
      if (i == 0) v_cyc = cyc;
      got = 1'b0;
      t   = 0;
      while (!got && t < TMO) begin
        @(negedge clk);
        t++;
        if ((r == 0) ? rdy0 : rdy1) got = 1'b1;
      end
      if (got) begin
        @(posedge clk);
        #1;
      end
      req_valid[r] = 1'b0;
      req_last[r]  = 1'b0;
      if (!got) begin
        check("xfer_timeout", 64'd1, 64'd0);
        return;
      end
    end
  endtask

  task automatic wait_idle(input int n);
    int t;
    t = 0;
    while (iq.size() < n && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check("release_count", 64'(iq.size()), 64'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       tbl[$];
    int         v0, v1, t, ks, km, dc, nknown, ex;
    logic [1:0] first_g, second_g;
    string      rm[2][NM];
    string      pool;
    ev_t        eq[$];

    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_char[0]  = 8'h00; req_char[1] = 8'h00;
    req_last[0]  = 1'b0; req_last[1]  = 1'b0;
`ifdef MORSE_SCHED_PRIORITY_EN
    first_g = 2'b10; second_g = 2'b01;
`else
    first_g = 2'b01; second_g = 2'b10;
`endif

    // Reset values.
    #2 rst_n = 1'b0;
    #1;
    check("rst_start", 64'(start), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_char",  64'(o_char), 64'd0);
    check("rst_ready", 64'({rdy1, rdy0}), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Tie right after reset.
    clear_logs();
    fork
      send_msg(0, "E", 0, 0, v0);
      send_msg(1, "T", 0, 0, v1);
    join
    wait_idle(2);
    check("tie_grants", 64'(gq.size()), 64'd2);
    if (gq.size() >= 2) begin
      check("tie_first",  64'(gq[0]), 64'(first_g));
      check("tie_second", 64'(gq[1]), 64'(second_g));
    end

    // Directed single-requester messages (done delay 10).
    tbl.push_back('{0, "E",   1, 21});
    tbl.push_back('{1, "ET",  2, 42});
    tbl.push_back('{0, "#",   0, 2});
    tbl.push_back('{1, " ",   0, 29});
    tbl.push_back('{0, "A#",  1, 23});
    tbl.push_back('{1, "#E",  1, 23});
    tbl.push_back('{0, "A B", 2, 71});
    tbl.push_back('{1, " B",  1, 50});
    for (int k = 0; k < tbl.size(); k++) begin
      clear_logs();
      send_msg(tbl[k].req, tbl[k].msg, 0, 0, v0);
      wait_idle(1);
      check("tbl_xfers",  64'(xq.size()), 64'(tbl[k].msg.len()));
      check("tbl_starts", 64'(sq.size()), 64'(tbl[k].starts));
      if (xq.size() > 0 && iq.size() > 0) begin
        check("tbl_lat", 64'(xq[0].cyc - v0), 64'd1);
        check("tbl_dur", 64'(iq[0] - xq[0].cyc), 64'(tbl[k].dur));
      end
      if (gq.size() > 0) check("tbl_grant", 64'(gq[0]), 64'(2'b01 << tbl[k].req));
      for (int i = 0; i + 1 < xq.size(); i++)
        check("tbl_span", 64'(xq[i+1].cyc - xq[i].cyc), 64'(char_span(xq[i].ch, eng_delay)));
      for (int i = 0; i < sq.size(); i++)
        check("tbl_start_gnt", 64'(sq[i].gnt), 64'(2'b01 << tbl[k].req));
      check("tbl_end_grant", 64'(grant), 64'd0);
      check("tbl_end_busy",  64'(busy),  64'd0);
    end

    // No preemption while the owner holds Valid low mid-message.
    clear_logs();
    fork
      send_msg(0, "ET", 30, 30, v0);
      begin
        repeat (3) @(posedge clk);
        #1;
        send_msg(1, "A", 0, 0, v1);
      end
    join
    wait_idle(2);
    check("np_xfers", 64'(xq.size()), 64'd3);
    if (xq.size() == 3 && iq.size() >= 1) begin
      check("np_order", 64'({xq[1].gnt, xq[2].gnt}), 64'({2'b01, 2'b10}));
      check("np_handover", 64'(xq[2].cyc), 64'(iq[0] + 1));
    end

    // Asynchronous reset while the engine is busy.
    clear_logs();
    send_msg(0, "E", 0, 0, v0);
    wait_idle(1);
    eng_en = 1'b0;
    send_msg(1, "T", 0, 0, v1);
    t = 0;
    while (!start && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check("ar_start_seen", 64'(start), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_start", 64'(start), 64'd0);
    check("ar_grant", 64'(grant), 64'd0);
    check("ar_busy",  64'(busy),  64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    eng_en = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    fork
      send_msg(0, "E", 0, 0, v0);
      send_msg(1, "E", 0, 0, v1);
    join
    wait_idle(2);
    if (gq.size() > 0) check("ar_tie_first", 64'(gq[0]), 64'(first_g));
    else check("ar_tie_seen", 64'(gq.size()), 64'd1);

    // Randomized messages against a message-level reference model.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_logs();
    eng_rand = 1'b1;
    pool = "ETAINS09 #?";
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NM; k++) begin
        rm[r][k] = "";
        for (int i = 0; i < int'($urandom_range(4, 1)); i++)
          rm[r][k] = $sformatf("%s%c", rm[r][k], pool[$urandom_range(pool.len() - 1, 0)]);
      end
    fork
      for (int k = 0; k < NM; k++) send_msg(0, rm[0][k], 0, 3, v0);
      for (int k = 0; k < NM; k++) send_msg(1, rm[1][k], 0, 3, v1);
    join
    wait_idle(2 * NM);

    for (int j = 0; j < 2 * NM; j++) begin
      int r, k;
`ifdef MORSE_SCHED_PRIORITY_EN
      r = (j < NM) ? 1 : 0;
      k = j % NM;
`else
      r = j % 2;
      k = j / 2;
`endif
      for (int i = 0; i < rm[r][k].len(); i++)
        eq.push_back('{2'b01 << r, rm[r][k][i], (i == rm[r][k].len() - 1), 0});
    end
    nknown = 0;
    foreach (eq[i]) if (is_known(eq[i].ch)) nknown++;
    check("rnd_xfers",    64'(xq.size()), 64'(eq.size()));
    check("rnd_starts",   64'(sq.size()), 64'(nknown));
    check("rnd_dones",    64'(dq.size()), 64'(nknown));
    check("rnd_releases", 64'(iq.size()), 64'(2 * NM));
    if (xq.size() == eq.size() && sq.size() == nknown && dq.size() == nknown && iq.size() == 2 * NM) begin
      ks = 0;
      km = 0;
      dc = 0;
      for (int i = 0; i < eq.size(); i++) begin
        check("rnd_gnt",  64'(xq[i].gnt),  64'(eq[i].gnt));
        check("rnd_char", 64'(xq[i].ch),   64'(eq[i].ch));
        check("rnd_last", 64'(xq[i].last), 64'(eq[i].last));
        if (is_known(eq[i].ch)) begin
          check("rnd_start_char", 64'(sq[ks].ch),  64'(eq[i].ch));
          check("rnd_start_gnt",  64'(sq[ks].gnt), 64'(eq[i].gnt));
          check("rnd_start_lat",  64'(sq[ks].cyc - xq[i].cyc), 64'd2);
          dc = dq[ks];
          ks++;
        end
        if (eq[i].last) begin
          if (is_known(eq[i].ch)) ex = dc + LETTER_CYC + 1;
          else ex = xq[i].cyc + char_span(eq[i].ch, 0);
          check("rnd_release", 64'(iq[km]), 64'(ex));
          km++;
        end
      end
    end
    check("rnd_end_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
